sdram_init_monitor: RTL

Device-side checker for the SDRAM power-up initialization protocol. It samples the command and address bus that the controller drives toward the SDRAM and tracks the JEDEC-style sequence: power-up wait, PRECHARGE ALL, auto-refreshes, then MODE REGISTER SET. It enforces the minimum command spacings and decodes the programmed mode register. It sits beside the SDRAM pins, in simulation or in-system, and signals either a clean `init_done` or a sticky error code.

---
 rtl/sdram_init_monitor.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor: watches the SDRAM command/address pins during power-up
// and checks the init sequence (wait, PRECHARGE ALL, AREFs, MODE REGISTER SET).
// Reports init_done on a clean sequence, or a sticky first-error code.
// dbg_state exposes the FSM state for external checkers.
module sdram_init_monitor #(
  parameter int DELAY_200US = 10000,
  parameter int T_RP        = 1,
  parameter int T_RFC       = 4,
  parameter int T_MRD       = 2,
  parameter int AREF_NUM    = 2
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic [3:0]  cmd,
  input  logic [12:0] addr,
  output logic        init_done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [2:0]  burst_len,
  output logic        burst_type,
  output logic [2:0]  cas_lat,
  output logic        wb_single,
  output logic [2:0]  dbg_state
);

  localparam int PWR_W = $clog2(DELAY_200US + 1);
  localparam logic [PWR_W-1:0] PWR_MAX = PWR_W'(DELAY_200US);

  typedef enum logic [2:0] {
    S_PWRUP    = 3'd0,
    S_WAIT_PRE = 3'd1,
    S_REFRESH  = 3'd2,
    S_MRD      = 3'd3,
    S_READY    = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [7:0]        req_gap_q, req_gap_d;
  logic [3:0]        aref_cnt_q, aref_cnt_d;
  logic [7:0]        mrd_cnt_q, mrd_cnt_d;
  logic              init_done_q, init_done_d;
  logic              err_q, err_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [2:0]        burst_len_q, burst_len_d;
  logic              burst_type_q, burst_type_d;
  logic [2:0]        cas_lat_q, cas_lat_d;
  logic              wb_single_q, wb_single_d;

  // Command decode; INHIBIT (CS_n high) behaves exactly like NOP.
  logic is_nop, is_pre, is_aref, is_mset;
  logic gap_ok, mode_ok, capture;
  logic [2:0] fail_code;

  assign is_nop  = cmd[3] | (cmd == 4'b0111);
  assign is_pre  = (cmd == 4'b0010);
  assign is_aref = (cmd == 4'b0001);
  assign is_mset = (cmd == 4'b0000);

  // A command n edges after the previous one has n = gap_cnt_q + 1.
  assign gap_ok = ({1'b0, gap_cnt_q} + 9'd1) >= {1'b0, req_gap_q};

  // Mode word legality: burst length, CAS latency and reserved bits.
  assign mode_ok = ((addr[2:0] <= 3'd3) || ((addr[2:0] == 3'd7) && !addr[3])) &&
                   ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) &&
                   (addr[12:10] == 3'd0) && (addr[8:7] == 2'd0);

  // Next-state, counters, error detection and mode capture.
  always_comb begin
    state_d      = state_q;
    pwr_cnt_d    = (pwr_cnt_q != PWR_MAX) ? pwr_cnt_q + 1'b1 : pwr_cnt_q;
    gap_cnt_d    = !is_nop ? 8'd0 : ((gap_cnt_q != 8'hFF) ? gap_cnt_q + 8'd1 : gap_cnt_q);
    req_gap_d    = req_gap_q;
    aref_cnt_d   = aref_cnt_q;
    mrd_cnt_d    = mrd_cnt_q;
    init_done_d  = init_done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    burst_len_d  = burst_len_q;
    burst_type_d = burst_type_q;
    cas_lat_d    = cas_lat_q;
    wb_single_d  = wb_single_q;
    capture      = 1'b0;
    fail_code    = 3'd0;

    if (is_pre)       req_gap_d = 8'(T_RP);
    else if (is_aref) req_gap_d = 8'(T_RFC);
    else if (!is_nop) req_gap_d = 8'd0;

    case (state_q)
      S_PWRUP: begin
        if (!is_nop && (pwr_cnt_q < PWR_MAX)) fail_code = 3'd1;
        else if (pwr_cnt_d == PWR_MAX)        state_d = S_WAIT_PRE;
      end
      S_WAIT_PRE: begin
        if (!is_nop) begin
          if (!gap_ok)      fail_code = 3'd3;
          else if (is_pre) begin
            if (addr[10]) begin
              state_d    = S_REFRESH;
              aref_cnt_d = 4'd0;
            end else begin
              fail_code = 3'd2;
            end
          end else          fail_code = 3'd4;
        end
      end
      S_REFRESH: begin
        if (!is_nop) begin
          if (!gap_ok) fail_code = 3'd3;
          else if (is_aref) begin
            if (aref_cnt_q != 4'd15) aref_cnt_d = aref_cnt_q + 4'd1;
          end else if (is_mset && ({1'b0, aref_cnt_q} >= 5'(AREF_NUM))) begin
            capture = 1'b1;
            if (mode_ok) begin
              state_d   = S_MRD;
              mrd_cnt_d = 8'd0;
            end else begin
              fail_code = 3'd5;
            end
          end else fail_code = 3'd4;
        end
      end
      S_MRD: begin
        if (!is_nop) fail_code = 3'd3;
        else begin
          mrd_cnt_d = mrd_cnt_q + 8'd1;
          if (({1'b0, mrd_cnt_q} + 9'd1) >= 9'(T_MRD)) begin
            state_d     = S_READY;
            init_done_d = 1'b1;
          end
        end
      end
      S_READY: begin
        if (is_mset) begin
          capture = 1'b1;
          if (!mode_ok) fail_code = 3'd5;
        end
      end
      default: ;
    endcase

    if (capture) begin
      burst_len_d  = addr[2:0];
      burst_type_d = addr[3];
      cas_lat_d    = addr[6:4];
      wb_single_d  = addr[9];
    end

    // ERROR never raises a new fail_code, so the first code is kept.
    if (fail_code != 3'd0) begin
      state_d     = S_ERROR;
      err_d       = 1'b1;
      err_code_d  = fail_code;
      init_done_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_PWRUP;
      pwr_cnt_q    <= '0;
      gap_cnt_q    <= 8'd0;
      req_gap_q    <= 8'd0;
      aref_cnt_q   <= 4'd0;
      mrd_cnt_q    <= 8'd0;
      init_done_q  <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 3'd0;
      burst_len_q  <= 3'd0;
      burst_type_q <= 1'b0;
      cas_lat_q    <= 3'd0;
      wb_single_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwr_cnt_q    <= pwr_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      req_gap_q    <= req_gap_d;
      aref_cnt_q   <= aref_cnt_d;
      mrd_cnt_q    <= mrd_cnt_d;
      init_done_q  <= init_done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      burst_len_q  <= burst_len_d;
      burst_type_q <= burst_type_d;
      cas_lat_q    <= cas_lat_d;
      wb_single_q  <= wb_single_d;
    end
  end

  assign init_done  = init_done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign burst_len  = burst_len_q;
  assign burst_type = burst_type_q;
  assign cas_lat    = cas_lat_q;
  assign wb_single  = wb_single_q;
  assign dbg_state  = state_q;

endmodule
